// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IF fetch and MEM load/store, MEM has priority
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    iCLK,
  input  logic                    iRST_n,
  input  logic                    iIF_Req,
  input  logic [ADDR_WIDTH-1:0]   iIF_Addr,
  input  logic                    iIF_Flush,
  output logic [DATA_WIDTH-1:0]   oIF_RData,
  output logic                    oIF_Done,
  output logic                    oIF_Stall,
  input  logic                    iMEM_Req,
  input  logic                    iMEM_Write,
  input  logic [ADDR_WIDTH-1:0]   iMEM_Addr,
  input  logic [DATA_WIDTH-1:0]   iMEM_WData,
  input  logic [DATA_WIDTH/8-1:0] iMEM_ByteEn,
  output logic [DATA_WIDTH-1:0]   oMEM_RData,
  output logic                    oMEM_Done,
  output logic                    oMEM_Stall,
  output logic                    oMem_Req,
  output logic                    oMem_Write,
  output logic [ADDR_WIDTH-1:0]   oMem_Addr,
  output logic [DATA_WIDTH-1:0]   oMem_WData,
  output logic [DATA_WIDTH/8-1:0] oMem_ByteEn,
  input  logic                    iMem_Ack,
  input  logic [DATA_WIDTH-1:0]   iMem_RData,
  output logic                    oTimeoutErr
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    INST,
    INST_DROP
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           wait_cnt_q, wait_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  if_done_q, if_done_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  data_done_q, data_done_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  data_grant;
  logic                  inst_grant;
  logic [16:0]           wait_next;
  logic                  timeout_hit;

  // A requester still showing its Done pulse has not yet dropped its request.
  assign data_grant  = iMEM_Req & ~data_done_q;
  assign inst_grant  = iIF_Req & ~iIF_Flush & ~if_done_q;
  assign wait_next   = {1'b0, wait_cnt_q} + 17'd1;
  assign timeout_hit = (wait_next >= TIMEOUT_LIMIT);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_req_d     = mem_req_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    if_rdata_d    = if_rdata_q;
    if_done_d     = 1'b0;
    data_rdata_d  = data_rdata_q;
    data_done_d   = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (data_grant) begin
          mem_req_d   = 1'b1;
          mem_write_d = iMEM_Write;
          mem_addr_d  = iMEM_Addr;
          mem_wdata_d = iMEM_WData;
          mem_be_d    = iMEM_ByteEn;
          wait_cnt_d  = '0;
          state_d     = DATA;
        end else if (inst_grant) begin
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = iIF_Addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          wait_cnt_d  = '0;
          state_d     = INST;
        end
      end

      DATA: begin
        if (iMem_Ack) begin
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          if (!mem_write_q) begin
            data_rdata_d = iMem_RData;
          end
          data_done_d = 1'b1;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          // Still complete the access so the pipeline is not frozen forever.
          mem_req_d     = 1'b0;
          mem_write_d   = 1'b0;
          data_rdata_d  = '0;
          data_done_d   = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      INST: begin
        if (iMem_Ack) begin
          // Completion beats a same-cycle flush; IF discards it on its side.
          mem_req_d  = 1'b0;
          if_rdata_d = iMem_RData;
          if_done_d  = 1'b1;
          state_d    = IDLE;
        end else if (iIF_Flush) begin
          wait_cnt_d = '0;
          state_d    = INST_DROP;
        end else if (timeout_hit) begin
          mem_req_d     = 1'b0;
          if_rdata_d    = '0;
          if_done_d     = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      INST_DROP: begin
        if (iMem_Ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      if_rdata_q    <= '0;
      if_done_q     <= 1'b0;
      data_rdata_q  <= '0;
      data_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      if_rdata_q    <= if_rdata_d;
      if_done_q     <= if_done_d;
      data_rdata_q  <= data_rdata_d;
      data_done_q   <= data_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign oMem_Req    = mem_req_q;
  assign oMem_Write  = mem_write_q;
  assign oMem_Addr   = mem_addr_q;
  assign oMem_WData  = mem_wdata_q;
  assign oMem_ByteEn = mem_be_q;
  assign oIF_RData   = if_rdata_q;
  assign oIF_Done    = if_done_q;
  assign oMEM_RData  = data_rdata_q;
  assign oMEM_Done   = data_done_q;
  assign oTimeoutErr = timeout_err_q;
  assign oIF_Stall   = iIF_Req & ~if_done_q;
  assign oMEM_Stall  = iMEM_Req & ~data_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scenario and randomized checks of mem_port_arbiter against a priority/latency model
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 4;

  logic          iCLK = 1'b0;
  logic          iRST_n;
  logic          iIF_Req, iIF_Flush;
  logic [AW-1:0] iIF_Addr;
  logic [DW-1:0] oIF_RData;
  logic          oIF_Done, oIF_Stall;
  logic          iMEM_Req, iMEM_Write;
  logic [AW-1:0] iMEM_Addr;
  logic [DW-1:0] iMEM_WData;
  logic [BW-1:0] iMEM_ByteEn;
  logic [DW-1:0] oMEM_RData;
  logic          oMEM_Done, oMEM_Stall;
  logic          oMem_Req, oMem_Write;
  logic [AW-1:0] oMem_Addr;
  logic [DW-1:0] oMem_WData;
  logic [BW-1:0] oMem_ByteEn;
  logic          iMem_Ack;
  logic [DW-1:0] iMem_RData;
  logic          oTimeoutErr;

  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] exp_mem_rdata;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .iIF_Req(iIF_Req), .iIF_Addr(iIF_Addr), .iIF_Flush(iIF_Flush),
    .oIF_RData(oIF_RData), .oIF_Done(oIF_Done), .oIF_Stall(oIF_Stall),
    .iMEM_Req(iMEM_Req), .iMEM_Write(iMEM_Write), .iMEM_Addr(iMEM_Addr),
    .iMEM_WData(iMEM_WData), .iMEM_ByteEn(iMEM_ByteEn),
    .oMEM_RData(oMEM_RData), .oMEM_Done(oMEM_Done), .oMEM_Stall(oMEM_Stall),
    .oMem_Req(oMem_Req), .oMem_Write(oMem_Write), .oMem_Addr(oMem_Addr),
    .oMem_WData(oMem_WData), .oMem_ByteEn(oMem_ByteEn),
    .iMem_Ack(iMem_Ack), .iMem_RData(iMem_RData), .oTimeoutErr(oTimeoutErr)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge iCLK);
  endtask

  // Waits (bounded) for the memory request; returns the number of cycles taken.
  task automatic wait_req(output int cyc);
    cyc = 0;
    do begin
      @(negedge iCLK);
      cyc++;
    end while (!oMem_Req && cyc < 20);
  endtask

  // Memory responder: ack d cycles after the current one; returns on the cycle after the ack.
  task automatic pulse_ack(input int d, input logic [DW-1:0] rd);
    repeat (d) @(negedge iCLK);
    iMem_Ack   = 1'b1;
    iMem_RData = rd;
    @(negedge iCLK);
    iMem_Ack   = 1'b0;
    iMem_RData = $urandom;
  endtask

  task automatic test_reset();
    iRST_n = 1'b0; iIF_Req = 0; iIF_Flush = 0; iIF_Addr = '0;
    iMEM_Req = 0; iMEM_Write = 0; iMEM_Addr = '0; iMEM_WData = '0; iMEM_ByteEn = '0;
    iMem_Ack = 0; iMem_RData = '0;
    exp_mem_rdata = '0;
    repeat (2) step();
    n_total++;
    if ({oMem_Req, oMem_Write, oMem_Addr, oMem_WData, oMem_ByteEn, oIF_RData, oIF_Done,
         oMEM_RData, oMEM_Done, oTimeoutErr} !== '0)
      $display("FAIL reset_outputs: req=%b wr=%b addr=%h ifd=%b memd=%b err=%b, all must be 0",
               oMem_Req, oMem_Write, oMem_Addr, oIF_Done, oMEM_Done, oTimeoutErr);
    else n_pass++;
    iRST_n = 1'b1;
    step();
    iMem_Ack = 1'b1; iMem_RData = 32'hFFFF_FFFF;
    step();
    iMem_Ack = 1'b0;
    n_total++;
    if ({oMem_Req, oIF_Done, oMEM_Done} !== 3'b000)
      $display("FAIL idle_ack_ignored: req/ifdone/memdone=%b want 000", {oMem_Req, oIF_Done, oMEM_Done});
    else n_pass++;
  endtask

  task automatic test_isolated_load();
    int c;
    iMEM_Req = 1; iMEM_Write = 0; iMEM_Addr = 32'h100; iMEM_WData = 32'h0; iMEM_ByteEn = 4'hF;
    #1;
    n_total++;
    if (oMEM_Stall !== 1'b1) $display("FAIL load_stall_early: got %b want 1", oMEM_Stall); else n_pass++;
    wait_req(c);
    n_total++;
    if (!oMem_Req || c != 1) $display("FAIL load_issue_latency: req=%b cycles=%0d want 1", oMem_Req, c); else n_pass++;
    n_total++;
    if (oMem_Addr !== 32'h100 || oMem_Write !== 1'b0)
      $display("FAIL load_fields: addr=%h wr=%b want 00000100/0", oMem_Addr, oMem_Write);
    else n_pass++;
    repeat (3) begin
      n_total++;
      if (oMEM_Done !== 1'b0 || oMEM_Stall !== 1'b1 || oMem_Req !== 1'b1)
        $display("FAIL load_wait: done=%b stall=%b req=%b want 0/1/1", oMEM_Done, oMEM_Stall, oMem_Req);
      else n_pass++;
      step();
    end
    pulse_ack(0, 32'hDEADBEEF);
    exp_mem_rdata = 32'hDEADBEEF;
    n_total++;
    if (oMEM_Done !== 1'b1 || oMEM_RData !== 32'hDEADBEEF || oMEM_Stall !== 1'b0 || oMem_Req !== 1'b0)
      $display("FAIL load_done: done=%b rdata=%h stall=%b req=%b want 1/deadbeef/0/0",
               oMEM_Done, oMEM_RData, oMEM_Stall, oMem_Req);
    else n_pass++;
    iMEM_Req = 0;
    step();
    n_total++;
    if (oMEM_Done !== 1'b0 || oMem_Req !== 1'b0)
      $display("FAIL load_done_pulse: done=%b req=%b want 0/0", oMEM_Done, oMem_Req);
    else n_pass++;
  endtask

  task automatic test_contention();
    int c;
    iMEM_Req = 1; iMEM_Write = 1; iMEM_Addr = 32'h200; iMEM_WData = 32'h55AA00FF; iMEM_ByteEn = 4'b0011;
    iIF_Req = 1; iIF_Addr = 32'h40;
    wait_req(c);
    n_total++;
    if (c != 1 || oMem_Write !== 1'b1 || oMem_ByteEn !== 4'b0011 || oMem_WData !== 32'h55AA00FF ||
        oMem_Addr !== 32'h200)
      $display("FAIL cont_store_first: cyc=%0d wr=%b be=%b wd=%h addr=%h want 1/1/0011/55aa00ff/200",
               c, oMem_Write, oMem_ByteEn, oMem_WData, oMem_Addr);
    else n_pass++;
    n_total++;
    if (oIF_Stall !== 1'b1) $display("FAIL cont_if_stall: got %b want 1", oIF_Stall); else n_pass++;
    pulse_ack($urandom_range(0, 3), 32'h12345678);
    n_total++;
    if (oMEM_Done !== 1'b1 || oMEM_RData !== exp_mem_rdata || oIF_Done !== 1'b0)
      $display("FAIL cont_store_done: done=%b rdata=%h ifdone=%b want 1/%h/0",
               oMEM_Done, oMEM_RData, oIF_Done, exp_mem_rdata);
    else n_pass++;
    iMEM_Req = 0;
    wait_req(c);
    n_total++;
    if (c != 1 || oMem_Addr !== 32'h40 || oMem_Write !== 1'b0 || oMem_ByteEn !== 4'hF)
      $display("FAIL cont_fetch_issue: cyc=%0d addr=%h wr=%b be=%b want 1/40/0/1111",
               c, oMem_Addr, oMem_Write, oMem_ByteEn);
    else n_pass++;
    pulse_ack(1, 32'hA5A50040);
    n_total++;
    if (oIF_Done !== 1'b1 || oIF_RData !== 32'hA5A50040)
      $display("FAIL cont_fetch_done: done=%b rdata=%h want 1/a5a50040", oIF_Done, oIF_RData);
    else n_pass++;
    iIF_Req = 0;
    step();
  endtask

  task automatic test_flush_in_flight();
    int c;
    iIF_Req = 1; iIF_Addr = 32'h400;
    wait_req(c);
    n_total++;
    if (c != 1 || oMem_Addr !== 32'h400) $display("FAIL flush_fetch_issue: cyc=%0d addr=%h want 1/400", c, oMem_Addr);
    else n_pass++;
    step();
    iIF_Flush = 1;
    step();
    iIF_Flush = 0; iIF_Addr = 32'h800;
    iMem_Ack = 1; iMem_RData = 32'hBADBAD00;
    step();
    iMem_Ack = 0;
    n_total++;
    if (oIF_Done !== 1'b0 || oMem_Req !== 1'b0)
      $display("FAIL flush_dropped: ifdone=%b req=%b want 0/0", oIF_Done, oMem_Req);
    else n_pass++;
    wait_req(c);
    n_total++;
    if (c != 1 || oMem_Addr !== 32'h800) $display("FAIL flush_refetch_issue: cyc=%0d addr=%h want 1/800", c, oMem_Addr);
    else n_pass++;
    pulse_ack(0, 32'hCAFE0800);
    n_total++;
    if (oIF_Done !== 1'b1 || oIF_RData !== 32'hCAFE0800)
      $display("FAIL flush_refetch_done: done=%b rdata=%h want 1/cafe0800", oIF_Done, oIF_RData);
    else n_pass++;
    iIF_Req = 0;
    step();
  endtask

  task automatic test_flush_on_ack();
    int c;
    iIF_Req = 1; iIF_Addr = 32'h900; iIF_Flush = 1;
    step();
    n_total++;
    if (oMem_Req !== 1'b0) $display("FAIL idle_flush_mask: req=%b want 0", oMem_Req); else n_pass++;
    iIF_Flush = 0;
    wait_req(c);
    n_total++;
    if (c != 1 || oMem_Addr !== 32'h900) $display("FAIL ackflush_issue: cyc=%0d addr=%h want 1/900", c, oMem_Addr);
    else n_pass++;
    iMem_Ack = 1; iMem_RData = 32'h09001234; iIF_Flush = 1;
    step();
    iMem_Ack = 0; iIF_Flush = 0;
    n_total++;
    if (oIF_Done !== 1'b1 || oIF_RData !== 32'h09001234)
      $display("FAIL ackflush_done: done=%b rdata=%h want 1/09001234", oIF_Done, oIF_RData);
    else n_pass++;
    iIF_Req = 0;
    step();
  endtask

  // Model: MEM always goes first, each grant issues one cycle after it is seen, Done one cycle after ack.
  task automatic test_back_to_back();
    int c, d, kind;
    logic has_mem, has_if, m_wr;
    logic [AW-1:0] m_addr, f_addr;
    logic [DW-1:0] m_wd, rd;
    logic [BW-1:0] m_be;
    for (int i = 0; i < 24; i++) begin
      kind    = $urandom_range(0, 2);
      has_mem = (kind != 1);
      has_if  = (kind != 0);
      m_addr  = $urandom & 32'hFFFF_FFFC;
      f_addr  = $urandom & 32'hFFFF_FFFC;
      m_wr    = 1'($urandom_range(0, 1));
      m_wd    = $urandom;
      m_be    = 4'($urandom_range(0, 15));
      iMEM_Req = has_mem; iMEM_Write = m_wr; iMEM_Addr = m_addr; iMEM_WData = m_wd; iMEM_ByteEn = m_be;
      iIF_Req = has_if; iIF_Addr = f_addr;
      if (has_mem) begin
        wait_req(c);
        n_total++;
        if (c != 1 || oMem_Addr !== m_addr || oMem_Write !== m_wr || oMem_WData !== m_wd || oMem_ByteEn !== m_be)
          $display("FAIL rnd_mem_issue[%0d]: cyc=%0d addr=%h wr=%b wd=%h be=%b want 1/%h/%b/%h/%b",
                   i, c, oMem_Addr, oMem_Write, oMem_WData, oMem_ByteEn, m_addr, m_wr, m_wd, m_be);
        else n_pass++;
        d  = $urandom_range(0, TMO - 1);
        rd = $urandom;
        pulse_ack(d, rd);
        if (!m_wr) exp_mem_rdata = rd;
        n_total++;
        if (oMEM_Done !== 1'b1 || oMEM_RData !== exp_mem_rdata || oIF_Done !== 1'b0 || oIF_Stall !== has_if)
          $display("FAIL rnd_mem_done[%0d]: done=%b rdata=%h ifdone=%b ifstall=%b want 1/%h/0/%b",
                   i, oMEM_Done, oMEM_RData, oIF_Done, oIF_Stall, exp_mem_rdata, has_if);
        else n_pass++;
        iMEM_Req = 0;
      end
      if (has_if) begin
        wait_req(c);
        n_total++;
        if (c != 1 || oMem_Addr !== f_addr || oMem_Write !== 1'b0 || oMem_ByteEn !== 4'hF)
          $display("FAIL rnd_if_issue[%0d]: cyc=%0d addr=%h wr=%b be=%b want 1/%h/0/1111",
                   i, c, oMem_Addr, oMem_Write, oMem_ByteEn, f_addr);
        else n_pass++;
        d  = $urandom_range(0, TMO - 1);
        rd = $urandom;
        pulse_ack(d, rd);
        n_total++;
        if (oIF_Done !== 1'b1 || oIF_RData !== rd || oMEM_Done !== 1'b0)
          $display("FAIL rnd_if_done[%0d]: done=%b rdata=%h memdone=%b want 1/%h/0",
                   i, oIF_Done, oIF_RData, oMEM_Done, rd);
        else n_pass++;
        iIF_Req = 0;
      end
      step();
    end
  endtask

  task automatic test_timeout();
    int c, hi;
    iMEM_Req = 1; iMEM_Write = 0; iMEM_Addr = 32'h300;
    wait_req(c);
    hi = oMem_Req ? 1 : 0;
    while (hi > 0 && hi < 20) begin
      step();
      if (!oMem_Req) break;
      hi++;
    end
    n_total++;
    if (hi != TMO) $display("FAIL timeout_req_cycles: got %0d want %0d", hi, TMO); else n_pass++;
    exp_mem_rdata = '0;
    n_total++;
    if (oMEM_Done !== 1'b1 || oMEM_RData !== 32'h0 || oTimeoutErr !== 1'b1)
      $display("FAIL timeout_done: done=%b rdata=%h err=%b want 1/0/1", oMEM_Done, oMEM_RData, oTimeoutErr);
    else n_pass++;
    iMEM_Req = 0;
    step();
    iIF_Req = 1; iIF_Addr = 32'h44;
    wait_req(c);
    pulse_ack(2, 32'h44440044);
    n_total++;
    if (oIF_Done !== 1'b1 || oIF_RData !== 32'h44440044 || oTimeoutErr !== 1'b1)
      $display("FAIL timeout_sticky: ifdone=%b rdata=%h err=%b want 1/44440044/1", oIF_Done, oIF_RData, oTimeoutErr);
    else n_pass++;
    iIF_Req = 0;
    step();
  endtask

  task automatic test_reset_midop();
    int c;
    iMEM_Req = 1; iMEM_Write = 1; iMEM_Addr = 32'h500; iMEM_WData = 32'h1; iMEM_ByteEn = 4'hF;
    wait_req(c);
    step();
    iRST_n = 0;
    #1;
    n_total++;
    if ({oMem_Req, oMem_Write, oMem_Addr, oMem_WData, oMem_ByteEn, oIF_RData, oIF_Done,
         oMEM_RData, oMEM_Done, oTimeoutErr} !== '0)
      $display("FAIL async_reset: req=%b wr=%b addr=%h err=%b rdata=%h, all must be 0",
               oMem_Req, oMem_Write, oMem_Addr, oTimeoutErr, oMEM_RData);
    else n_pass++;
    iMEM_Req = 0;
    repeat (2) step();
    iRST_n = 1;
    step();
    iIF_Req = 1; iIF_Addr = 32'hA00;
    wait_req(c);
    n_total++;
    if (c != 1 || oMem_Addr !== 32'hA00 || oMem_Write !== 1'b0)
      $display("FAIL post_reset_issue: cyc=%0d addr=%h wr=%b want 1/a00/0", c, oMem_Addr, oMem_Write);
    else n_pass++;
    pulse_ack(1, 32'h600DF00D);
    n_total++;
    if (oIF_Done !== 1'b1 || oIF_RData !== 32'h600DF00D || oTimeoutErr !== 1'b0)
      $display("FAIL post_reset_fetch: done=%b rdata=%h err=%b want 1/600df00d/0", oIF_Done, oIF_RData, oTimeoutErr);
    else n_pass++;
    iIF_Req = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_isolated_load();
    test_contention();
    test_flush_in_flight();
    test_flush_on_ack();
    test_back_to_back();
    test_timeout();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
